// File: rtl/axi_rd_arb.sv
// axi_rd_arb: 2:1 AXI4 read arbiter (m0 = IFU fetch, m1 = LSU load) with in-order R routing.
// Define AXI_RD_ARB_LSU_PRIO_EN for fixed LSU priority; undefined gives round-robin.
module axi_rd_arb #(
  parameter int AXI_RD_OST_NUM = 8,
  parameter int OST_CNT_W      = 4,
  parameter int ID_W           = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_m0_arvalid,
  output logic              o_m0_arready,
  input  logic [ID_W-1:0]   i_m0_arid,
  input  logic [ADDR_W-1:0] i_m0_araddr,
  input  logic [7:0]        i_m0_arlen,
  input  logic [2:0]        i_m0_arsize,
  input  logic [1:0]        i_m0_arburst,
  input  logic              i_m0_arlock,
  input  logic [3:0]        i_m0_arcache,
  input  logic [2:0]        i_m0_arprot,
  input  logic [3:0]        i_m0_arqos,
  input  logic [3:0]        i_m0_arregion,
  output logic              o_m0_rvalid,
  input  logic              i_m0_rready,
  output logic [ID_W-1:0]   o_m0_rid,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic [1:0]        o_m0_rresp,
  output logic              o_m0_rlast,
  input  logic              i_m1_arvalid,
  output logic              o_m1_arready,
  input  logic [ID_W-1:0]   i_m1_arid,
  input  logic [ADDR_W-1:0] i_m1_araddr,
  input  logic [7:0]        i_m1_arlen,
  input  logic [2:0]        i_m1_arsize,
  input  logic [1:0]        i_m1_arburst,
  input  logic              i_m1_arlock,
  input  logic [3:0]        i_m1_arcache,
  input  logic [2:0]        i_m1_arprot,
  input  logic [3:0]        i_m1_arqos,
  input  logic [3:0]        i_m1_arregion,
  output logic              o_m1_rvalid,
  input  logic              i_m1_rready,
  output logic [ID_W-1:0]   o_m1_rid,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic [1:0]        o_m1_rresp,
  output logic              o_m1_rlast,
  output logic              o_s_arvalid,
  input  logic              i_s_arready,
  output logic [ID_W-1:0]   o_s_arid,
  output logic [ADDR_W-1:0] o_s_araddr,
  output logic [7:0]        o_s_arlen,
  output logic [2:0]        o_s_arsize,
  output logic [1:0]        o_s_arburst,
  output logic              o_s_arlock,
  output logic [3:0]        o_s_arcache,
  output logic [2:0]        o_s_arprot,
  output logic [3:0]        o_s_arqos,
  output logic [3:0]        o_s_arregion,
  input  logic              i_s_rvalid,
  output logic              o_s_rready,
  input  logic [ID_W-1:0]   i_s_rid,
  input  logic [DATA_W-1:0] i_s_rdata,
  input  logic [1:0]        i_s_rresp,
  input  logic              i_s_rlast,
  output logic [OST_CNT_W-1:0] o_ost_cnt
);

  localparam int AR_W  = ID_W + ADDR_W + 29;
  localparam int PTR_W = (AXI_RD_OST_NUM > 1) ? $clog2(AXI_RD_OST_NUM) : 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_gnt, w_gnt_nxt, w_load;
  logic [AR_W-1:0]       r_ar_pay, w_m0_pay, w_m1_pay;
  logic [AXI_RD_OST_NUM-1:0] r_fifo;
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [OST_CNT_W-1:0]  r_ost_cnt;
  logic                  w_full, w_empty, w_push, w_pop, w_head;
`ifndef AXI_RD_ARB_LSU_PRIO_EN
  logic                  r_last_gnt;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(AXI_RD_OST_NUM - 1)) ptr_inc = '0;
    else                                   ptr_inc = ptr + PTR_W'(1);
  endfunction

  assign w_m0_pay = {i_m0_arid, i_m0_araddr, i_m0_arlen, i_m0_arsize, i_m0_arburst,
                     i_m0_arlock, i_m0_arcache, i_m0_arprot, i_m0_arqos, i_m0_arregion};
  assign w_m1_pay = {i_m1_arid, i_m1_araddr, i_m1_arlen, i_m1_arsize, i_m1_arburst,
                     i_m1_arlock, i_m1_arcache, i_m1_arprot, i_m1_arqos, i_m1_arregion};
  assign {o_s_arid, o_s_araddr, o_s_arlen, o_s_arsize, o_s_arburst,
          o_s_arlock, o_s_arcache, o_s_arprot, o_s_arqos, o_s_arregion} = r_ar_pay;

  assign w_full       = (r_ost_cnt == OST_CNT_W'(AXI_RD_OST_NUM));
  assign w_empty      = (r_ost_cnt == '0);
  assign w_head       = r_fifo[r_rd_ptr];
  assign o_s_arvalid  = (r_state == ST_ISSUE);
  assign w_push       = o_s_arvalid & i_s_arready;
  // master handshake coincides with the slave handshake so a held arvalid is never re-granted
  assign o_m0_arready = w_push & ~r_gnt;
  assign o_m1_arready = w_push & r_gnt;
  assign o_ost_cnt    = r_ost_cnt;

  assign o_s_rready   = ~w_empty & (w_head ? i_m1_rready : i_m0_rready);
  assign o_m0_rvalid  = i_s_rvalid & ~w_empty & ~w_head;
  assign o_m1_rvalid  = i_s_rvalid & ~w_empty & w_head;
  assign w_pop        = i_s_rvalid & o_s_rready & i_s_rlast;

  assign o_m0_rid = i_s_rid;  assign o_m0_rdata = i_s_rdata;
  assign o_m0_rresp = i_s_rresp;  assign o_m0_rlast = i_s_rlast;
  assign o_m1_rid = i_s_rid;  assign o_m1_rdata = i_s_rdata;
  assign o_m1_rresp = i_s_rresp;  assign o_m1_rlast = i_s_rlast;

  // AR grant decision
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((i_m0_arvalid || i_m1_arvalid) && !w_full) begin
          w_state_nxt = ST_ISSUE;
          w_load      = 1'b1;
          if (i_m0_arvalid && i_m1_arvalid) begin
`ifdef AXI_RD_ARB_LSU_PRIO_EN
            w_gnt_nxt = 1'b1;
`else
            w_gnt_nxt = ~r_last_gnt;
`endif
          end else begin
            w_gnt_nxt = i_m1_arvalid;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (i_s_arready) w_state_nxt = ST_IDLE;
        else             w_state_nxt = ST_ISSUE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // AR state, grant and latched payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_gnt    <= 1'b0;
      r_ar_pay <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      if (w_load) r_ar_pay <= w_gnt_nxt ? w_m1_pay : w_m0_pay;
    end
  end

`ifndef AXI_RD_ARB_LSU_PRIO_EN
  // round-robin history, resets pointing at m1 so m0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_last_gnt <= 1'b1;
    else if (w_push) r_last_gnt <= r_gnt;
  end
`endif

  // in-order return FIFO of grant indices and outstanding count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo    <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ost_cnt <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= r_gnt;
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_ost_cnt <= r_ost_cnt + OST_CNT_W'(1);
        2'b01:   r_ost_cnt <= r_ost_cnt - OST_CNT_W'(1);
        default: r_ost_cnt <= r_ost_cnt;
      endcase
    end
  end

endmodule
